// File: rtl/plru_unit.sv
// rtl/plru_unit.sv - 4-way tree pseudo-LRU replacement engine with same-set write forwarding
module plru_unit #(
  parameter int S_INDEX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [S_INDEX-1:0] req_set,
  input  logic [1:0]         req_way,
  output logic               resp_valid,
  output logic [1:0]         resp_way,
  output logic               lru_csb0,
  output logic               lru_web0,
  output logic [S_INDEX-1:0] lru_addr0,
  input  logic [2:0]         lru_dout0,
  output logic               lru_csb1,
  output logic               lru_web1,
  output logic [S_INDEX-1:0] lru_addr1,
  output logic [2:0]         lru_din1
);

  typedef enum logic [1:0] {
    OP_HIT  = 2'b00,
    OP_MISS = 2'b01,
    OP_PEEK = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  logic               fire;
  logic               s1_valid;
  op_e                s1_op;
  logic [S_INDEX-1:0] s1_set;
  logic [1:0]         s1_way;

  logic               fwd_valid;
  logic [S_INDEX-1:0] fwd_set;
  logic [2:0]         fwd_bits;

  logic               forward;
  logic               active;
  logic               upd;
  logic [2:0]         cur;
  logic [1:0]         victim;
  logic [1:0]         target;
  logic [2:0]         new_bits;

  // No stalls: the unit accepts a request every cycle it is out of reset.
  assign req_ready = ~rst;
  assign fire      = req_valid & req_ready;

  // Stage 0 issues the tree-bit read for the accepted request; port 0 is read-only.
  always_comb begin
    lru_csb0  = ~fire;
    lru_web0  = 1'b1;
    lru_addr0 = rst ? '0 : req_set;
  end

  // Stage 1: pick the tree bits (forwarded or array), derive the victim, mark MRU, drive the write.
  always_comb begin
    forward  = fwd_valid & (fwd_set == s1_set);
    cur      = forward ? fwd_bits : lru_dout0;
    active   = s1_valid & ~rst;
    // HIT and MISS update the tree; PEEK and the reserved op only look.
    upd      = active & ~s1_op[1];
    victim   = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
    target   = (s1_op == OP_HIT) ? s1_way : victim;
    new_bits = cur;
    new_bits[0] = ~target[1];
    if (target[1]) new_bits[2] = ~target[0];
    else           new_bits[1] = ~target[0];

    resp_valid = active;
    resp_way   = active ? target : 2'b00;
    lru_csb1   = ~upd;
    lru_web1   = ~upd;
    lru_addr1  = upd ? s1_set : '0;
    lru_din1   = upd ? new_bits : 3'b000;
  end

  // Pipeline and forwarding registers; the forwarded copy lives exactly one cycle after each write.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_HIT;
      s1_set    <= '0;
      s1_way    <= 2'b00;
      fwd_valid <= 1'b0;
      fwd_set   <= '0;
      fwd_bits  <= 3'b000;
    end else begin
      s1_valid  <= fire;
      s1_op     <= op_e'(req_op);
      s1_set    <= req_set;
      s1_way    <= req_way;
      fwd_valid <= upd;
      if (upd) begin
        fwd_set  <= s1_set;
        fwd_bits <= new_bits;
      end
    end
  end

endmodule

// File: doc/plru_unit.md
# plru_unit

Pseudo-LRU replacement engine for the 4-way set-associative write-back cache. It sits directly upstream of the 3-bit-wide, 2^S_INDEX-entry dual-port flip-flop LRU state array and is its only master: it reads tree bits on port 0, computes the victim way, and writes updated tree bits on port 1. It serves hit-update, miss-allocate and peek requests from the cache controller at one request per cycle, with internal forwarding for back-to-back same-set requests.

## Interface
Parameters:
- S_INDEX, 4, set-index width; 2^S_INDEX sets.

Ports (one clock; `rst` is synchronous, active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit accepts request
- req_op  in  2  2'b00 HIT (mark req_way MRU), 2'b01 MISS (select victim, mark it MRU), 2'b10 PEEK (select victim, no update), 2'b11 reserved (treated as PEEK)
- req_set  in  S_INDEX  set index
- req_way  in  2  hit way (HIT only)
- resp_valid  out  1  response pulse, no backpressure
- resp_way  out  2  HIT: req_way; MISS/PEEK: victim
- lru_csb0  out  1  read-port select, active-low
- lru_web0  out  1  tied 1
- lru_addr0  out  S_INDEX  read address
- lru_dout0  in  3  read data, valid the cycle after the read is issued
- lru_csb1  out  1  write-port select, active-low
- lru_web1  out  1  write enable, active-low
- lru_addr1  out  S_INDEX  write address
- lru_din1  out  3  write data

## Operation
- Tree bits {b2,b1,b0}. b0: 0 = victim in ways 0/1, 1 = ways 2/3. b1: 0 = way0, 1 = way1. b2: 0 = way2, 1 = way3.
- Victim = b0 ? {1'b1,b2} : {1'b0,b1}.
- Mark way w MRU: b0 := ~w[1]. If w[1]==0, b1 := ~w[0]; otherwise b2 := ~w[0]. The untouched bit holds its value.
- Stage 0 (accept cycle): fire = req_valid & req_ready. Drive lru_csb0 = ~fire, lru_addr0 = req_set. Capture op, set and way into the stage-1 register.
- Stage 1 (next cycle):
  - cur = forward ? fwd_bits : lru_dout0.
  - Compute resp_way and new bits.
  - Assert resp_valid.
  - For HIT or MISS: lru_csb1 = 0, lru_web1 = 0, lru_addr1 = s1_set, lru_din1 = new bits.
  - For PEEK: lru_csb1 = 1, lru_web1 = 1.
- Forwarding. The array commits a port-1 write one edge after it registers it, so a read issued in the same cycle as a write returns stale data. Stage 1 keeps a fwd register {valid, set, bits} loaded with every write it issues, valid for exactly one following cycle. forward = fwd_valid & (fwd_set == s1_set). PEEK clears fwd_valid.
- req_ready = 1 every cycle out of reset. There are no stalls.

## Timing
- Response latency is exactly one cycle: request accepted in cycle C gives resp_valid in C+1. Throughput is one request per cycle.
- The array contents update at the end of C+2. A request accepted in C+1 or later for the same set observes the update, through forwarding in C+1 and through the array thereafter.
- Reset values:
  - resp_valid = 0, resp_way = 0.
  - req_ready = 0 while rst, 1 from the first cycle after rst deasserts.
  - lru_csb0 = 1, lru_web0 = 1, lru_csb1 = 1, lru_web1 = 1, lru_addr0/1 = 0, lru_din1 = 0.
  - The stage-1 valid bit and fwd_valid clear.
- The array resets its own contents to 3'b000 on the same rst.
- Reset mid-operation: a pending stage-1 request is dropped. No response and no write are issued.
- Port 0 never writes, so a dual-write collision in the array is impossible.

## Test plan
- Reset: hold rst 3 cycles -> all outputs at reset values, req_ready = 0. First cycle after release -> req_ready = 1.
- Four MISS requests to set 5, spaced 3 cycles apart -> resp_way 0, 2, 1, 3. Writes 3'b011, 3'b110, 3'b101, 3'b000.
- The same four MISS requests to set 5 back-to-back -> identical resp_way and din sequence, which proves forwarding.
- HIT way 2 on set 9, then MISS set 9 the next cycle -> HIT writes 3'b100. MISS returns victim 0 and writes 3'b111.
- Interleaved MISS set 1, MISS set 2, PEEK set 1 back-to-back -> victims 0, 0, 2. The PEEK issues no write (lru_csb1 = 1).
- MISS accepted, rst asserted the next cycle -> no resp_valid and no port-1 write. After release, MISS on the same set returns victim 0.
